// File: rtl/fft_bitrev_reader.sv
// Unload controller for the 64-word FFT result RAM: issues natural or bit-reversed
// read addresses and realigns the RAM's two-cycle read data with RDY/FIRST strobes.
module fft_bitrev_reader #(
    parameter int nb = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    input  logic          BITREV,
    output logic          RAM_ED,
    output logic          RAM_WE,
    output logic [5:0]    RAM_ADDR,
    input  logic [nb-1:0] RAM_DO,
    output logic [nb-1:0] DOUT,
    output logic          RDY,
    output logic          FIRST,
    output logic          BUSY
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t     state;
    logic [5:0] cnt;
    logic       mode;
    logic       drain_cnt;
    logic [2:0] vpipe;
    logic [2:0] fpipe;
    logic [5:0] cnt_rev;

    assign RAM_ED = ED;
    assign RAM_WE = 1'b0;
    assign BUSY   = (state != IDLE);
    assign RDY    = vpipe[2];
    assign FIRST  = fpipe[2];

    always_comb begin
        cnt_rev = '0;
        for (int i = 0; i < 6; i++) begin
            cnt_rev[i] = cnt[5-i];
        end
    end

    assign RAM_ADDR = (state == ISSUE) ? (mode ? cnt_rev : cnt) : 6'd0;

    // A START seen at the last address or during drain restarts issue without a gap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            mode      <= 1'b0;
            drain_cnt <= 1'b0;
        end else if (ED) begin
            case (state)
                IDLE: begin
                    if (START) begin
                        state <= ISSUE;
                        cnt   <= '0;
                        mode  <= BITREV;
                    end
                end
                ISSUE: begin
                    if (cnt == 6'd63) begin
                        cnt <= '0;
                        if (START) begin
                            mode <= BITREV;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                DRAIN: begin
                    if (START) begin
                        state <= ISSUE;
                        cnt   <= '0;
                        mode  <= BITREV;
                    end else if (drain_cnt) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vpipe <= '0;
            fpipe <= '0;
            DOUT  <= '0;
        end else if (ED) begin
            vpipe <= {vpipe[1:0], (state == ISSUE)};
            fpipe <= {fpipe[1:0], (state == ISSUE) && (cnt == 6'd0)};
            if (vpipe[1]) begin
                DOUT <= RAM_DO;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Self-checking bench for fft_bitrev_reader with a behavioural RAM64 stub and a
// sequence model derived from the frame ordering rules.
module tb_fft_bitrev_reader;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ED;
    logic        START;
    logic        BITREV;
    logic        RAM_ED;
    logic        RAM_WE;
    logic [5:0]  RAM_ADDR;
    logic [15:0] RAM_DO;
    logic [15:0] DOUT;
    logic        RDY;
    logic        FIRST;
    logic        BUSY;

    logic [15:0] mem [64];
    logic [5:0]  ramAddrQ;
    logic [15:0] capData [$];
    logic        capFirst [$];
    logic        edSampled;
    int          checks = 0;
    int          passes = 0;

    fft_bitrev_reader #(.nb(16)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START), .BITREV(BITREV),
        .RAM_ED(RAM_ED), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR), .RAM_DO(RAM_DO),
        .DOUT(DOUT), .RDY(RDY), .FIRST(FIRST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // RAM64 stub: address register then data register, both frozen by RAM_ED.
    always @(posedge CLK) begin
        if (RAM_ED) begin
            ramAddrQ <= RAM_ADDR;
            RAM_DO   <= mem[ramAddrQ];
        end
    end

    // Record one sample per enabled edge that leaves RDY high.
    always @(posedge CLK) begin
        edSampled = ED;
        #1;
        if (edSampled && RDY && !RST) begin
            capData.push_back(DOUT);
            capFirst.push_back(FIRST);
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int revIdx(input int k, input bit br);
        int r;
        r = 0;
        if (!br) return k;
        for (int b = 0; b < 6; b++)
            if (((k >> b) & 1) == 1) r += (1 << (5 - b));
        return r;
    endfunction

    task automatic loadRamp();
        for (int i = 0; i < 64; i++) mem[i] = 16'h0100 + 16'(i);
    endtask

    task automatic loadRandom();
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
    endtask

    task automatic startFrame(input bit br);
        START  = 1'b1;
        BITREV = br;
        @(negedge CLK);
        START  = 1'b0;
        BITREV = 1'b0;
    endtask

    task automatic waitIdle();
        int b;
        b = 0;
        while ((BUSY || RDY) && b < 400) begin
            @(negedge CLK);
            b++;
        end
        repeat (3) @(negedge CLK);
    endtask

    task automatic test_reset();
        ED = 1'b1; START = 1'b0; BITREV = 1'b0; RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if ({RDY, FIRST, BUSY} !== 3'b000) $display("[TB] FAIL reset_flags: got %b required 000", {RDY, FIRST, BUSY}); else passes++;
        checks++; if (DOUT !== 16'h0000) $display("[TB] FAIL reset_dout: got %h required 0000", DOUT); else passes++;
        checks++; if (RAM_ADDR !== 6'd0) $display("[TB] FAIL reset_addr: got %0d required 0", RAM_ADDR); else passes++;
        checks++; if (RAM_WE !== 1'b0) $display("[TB] FAIL ram_we: got %b required 0", RAM_WE); else passes++;
        ED = 1'b0; #1;
        checks++; if (RAM_ED !== 1'b0) $display("[TB] FAIL ram_ed_low: got %b required 0", RAM_ED); else passes++;
        ED = 1'b1; #1;
        checks++; if (RAM_ED !== 1'b1) $display("[TB] FAIL ram_ed_high: got %b required 1", RAM_ED); else passes++;
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (BUSY !== 1'b0 || RDY !== 1'b0) $display("[TB] FAIL idle_after_reset: got busy=%b rdy=%b required 0 0", BUSY, RDY); else passes++;
    endtask

    task automatic test_natural();
        int b;
        loadRamp();
        capData.delete(); capFirst.delete();
        startFrame(1'b0);
        checks++; if (BUSY !== 1'b1) $display("[TB] FAIL nat_busy: got %b required 1", BUSY); else passes++;
        for (int e = 1; e <= 3; e++) begin
            checks++; if (RDY !== 1'b0) $display("[TB] FAIL nat_latency_e%0d: got rdy=%b required 0", e, RDY); else passes++;
            @(negedge CLK);
        end
        checks++; if (RDY !== 1'b1 || FIRST !== 1'b1 || DOUT !== 16'h0100) $display("[TB] FAIL nat_first_sample: got rdy=%b first=%b dout=%h required 1 1 0100", RDY, FIRST, DOUT); else passes++;
        b = 0;
        while (capData.size() < 64 && b < 200) begin
            @(negedge CLK);
            b++;
        end
        checks++; if (BUSY !== 1'b0) $display("[TB] FAIL nat_busy_at_last: got %b required 0", BUSY); else passes++;
        waitIdle();
        checks++; if (capData.size() != 64) $display("[TB] FAIL nat_count: got %0d required 64", capData.size()); else passes++;
        for (int k = 0; k < 64 && k < capData.size(); k++) begin
            checks++; if (capData[k] !== mem[k]) $display("[TB] FAIL nat_data[%0d]: got %h required %h", k, capData[k], mem[k]); else passes++;
            checks++; if (capFirst[k] !== (k == 0)) $display("[TB] FAIL nat_first[%0d]: got %b required %b", k, capFirst[k], (k == 0)); else passes++;
        end
    endtask

    task automatic test_bitrev();
        loadRamp();
        capData.delete(); capFirst.delete();
        startFrame(1'b1);
        for (int k = 0; k < 64; k++) begin
            checks++; if (RAM_ADDR !== 6'(revIdx(k, 1'b1))) $display("[TB] FAIL rev_addr[%0d]: got %0d required %0d", k, RAM_ADDR, revIdx(k, 1'b1)); else passes++;
            @(negedge CLK);
        end
        waitIdle();
        checks++; if (capData.size() != 64) $display("[TB] FAIL rev_count: got %0d required 64", capData.size()); else passes++;
        for (int k = 0; k < 64 && k < capData.size(); k++) begin
            checks++; if (capData[k] !== mem[revIdx(k, 1'b1)]) $display("[TB] FAIL rev_data[%0d]: got %h required %h", k, capData[k], mem[revIdx(k, 1'b1)]); else passes++;
        end
    endtask

    task automatic test_stall();
        int b;
        logic [15:0] holdData;
        logic [5:0]  holdAddr;
        loadRandom();
        capData.delete(); capFirst.delete();
        startFrame(1'b0);
        b = 0;
        while (capData.size() < 11 && b < 100) begin
            @(negedge CLK);
            b++;
        end
        ED = 1'b0;
        holdData = DOUT;
        holdAddr = RAM_ADDR;
        checks++; if (holdData !== mem[10]) $display("[TB] FAIL stall_sample10: got %h required %h", holdData, mem[10]); else passes++;
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK);
            checks++; if (DOUT !== holdData || RDY !== 1'b1 || RAM_ADDR !== holdAddr) $display("[TB] FAIL stall_hold[%0d]: got dout=%h rdy=%b addr=%0d required %h 1 %0d", s, DOUT, RDY, RAM_ADDR, holdData, holdAddr); else passes++;
        end
        ED = 1'b1;
        waitIdle();
        checks++; if (capData.size() != 64) $display("[TB] FAIL stall_count: got %0d required 64", capData.size()); else passes++;
        for (int k = 0; k < 64 && k < capData.size(); k++) begin
            checks++; if (capData[k] !== mem[k]) $display("[TB] FAIL stall_data[%0d]: got %h required %h", k, capData[k], mem[k]); else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] expData [128];
        int b;
        int gaps;
        loadRandom();
        for (int k = 0; k < 128; k++)
            expData[k] = (k < 64) ? mem[k] : mem[revIdx(k - 64, 1'b1)];
        capData.delete(); capFirst.delete();
        startFrame(1'b0);
        repeat (63) @(negedge CLK);
        startFrame(1'b1);
        b = 0;
        gaps = 0;
        while (capData.size() < 128 && b < 300) begin
            if (capData.size() > 0 && !RDY) gaps++;
            @(negedge CLK);
            b++;
        end
        waitIdle();
        checks++; if (gaps != 0) $display("[TB] FAIL b2b_contiguous: got %0d gaps required 0", gaps); else passes++;
        checks++; if (capData.size() != 128) $display("[TB] FAIL b2b_count: got %0d required 128", capData.size()); else passes++;
        for (int k = 0; k < 128 && k < capData.size(); k++) begin
            checks++; if (capData[k] !== expData[k]) $display("[TB] FAIL b2b_data[%0d]: got %h required %h", k, capData[k], expData[k]); else passes++;
            checks++; if (capFirst[k] !== (k == 0 || k == 64)) $display("[TB] FAIL b2b_first[%0d]: got %b required %b", k, capFirst[k], (k == 0 || k == 64)); else passes++;
        end
    endtask

    task automatic test_ignored_start();
        int firsts;
        loadRandom();
        capData.delete(); capFirst.delete();
        startFrame(1'b0);
        repeat (20) @(negedge CLK);
        startFrame(1'b1);
        waitIdle();
        repeat (10) @(negedge CLK);
        checks++; if (capData.size() != 64) $display("[TB] FAIL ign_count: got %0d required 64", capData.size()); else passes++;
        firsts = 0;
        for (int k = 0; k < 64 && k < capData.size(); k++) begin
            if (capFirst[k]) firsts++;
            checks++; if (capData[k] !== mem[k]) $display("[TB] FAIL ign_data[%0d]: got %h required %h", k, capData[k], mem[k]); else passes++;
        end
        checks++; if (firsts != 1) $display("[TB] FAIL ign_first_count: got %0d required 1", firsts); else passes++;
    endtask

    task automatic test_reset_mid();
        int b;
        loadRamp();
        capData.delete(); capFirst.delete();
        startFrame(1'b0);
        b = 0;
        while (capData.size() < 31 && b < 100) begin
            @(negedge CLK);
            b++;
        end
        checks++; if (RDY !== 1'b1) $display("[TB] FAIL mid_pre_rdy: got %b required 1", RDY); else passes++;
        #2 RST = 1'b1;
        #1;
        checks++; if ({RDY, FIRST, BUSY} !== 3'b000 || DOUT !== 16'h0000) $display("[TB] FAIL mid_abort: got flags=%b dout=%h required 000 0000", {RDY, FIRST, BUSY}, DOUT); else passes++;
        @(negedge CLK);
        RST = 1'b0;
        capData.delete(); capFirst.delete();
        repeat (10) @(negedge CLK);
        checks++; if (capData.size() != 0 || BUSY !== 1'b0) $display("[TB] FAIL mid_no_more: got samples=%0d busy=%b required 0 0", capData.size(), BUSY); else passes++;
        startFrame(1'b0);
        waitIdle();
        checks++; if (capData.size() != 64) $display("[TB] FAIL mid_restart_count: got %0d required 64", capData.size()); else passes++;
        for (int k = 0; k < 64 && k < capData.size(); k++) begin
            checks++; if (capData[k] !== 16'h0100 + 16'(k)) $display("[TB] FAIL mid_restart[%0d]: got %h required %h", k, capData[k], 16'h0100 + 16'(k)); else passes++;
        end
    endtask

    initial begin
        RST = 1'b1; ED = 1'b1; START = 1'b0; BITREV = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_natural();
        test_bitrev();
        test_stall();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reader.md
Name: fft_bitrev_reader

Overview:
- Read-side controller for the 64-word single-port synchronous RAM buffer (RAM64) in the FFT pipeline.
- On START, issues 64 read addresses in natural or bit-reversed order and absorbs the RAM's 2-cycle read latency.
- Delivers the stream on DOUT with an aligned RDY strobe and a FIRST marker; it is the unload side of the FFT result buffer.

Parameters:
- nb, 16, data word width; must equal RAM64 nb (from `FFTsfpw).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- ED  in  1  global enable; low freezes all state.
- START  in  1  frame start request, sampled on enabled edges.
- BITREV  in  1  1 = bit-reversed address order, 0 = natural; latched with START.
- RAM_ED  out  1  RAM enable; combinationally equal to ED.
- RAM_WE  out  1  RAM write enable; constant 0.
- RAM_ADDR  out  6  RAM address.
- RAM_DO  in  nb  RAM read data.
- DOUT  out  nb  output sample, registered.
- RDY  out  1  DOUT valid.
- FIRST  out  1  high with the first sample of a frame.
- BUSY  out  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async, RST=1): state IDLE, cnt=0, latched BITREV=0, valid pipe cleared, DOUT=0, RDY=0, FIRST=0, BUSY=0. RAM_ADDR=0 while idle.
- All registers update only on rising CLK edges with ED=1 ("enabled edge"). With ED=0, everything holds: cnt, state, pipe, DOUT, RDY, FIRST. RAM_ED=ED, so the RAM freezes in lockstep.
- Address generation: RAM_ADDR = cnt in natural mode, {cnt[0],cnt[1],...,cnt[5]} in bit-reversed mode. RAM_ADDR is combinational from cnt and the latched mode, and is valid in ISSUE only.
- States:
  - IDLE: START=1 on an enabled edge -> ISSUE, cnt=0, latch BITREV.
  - ISSUE: cnt increments each enabled edge. At cnt=63:
    - if START=1 -> stay in ISSUE, cnt=0, relatch BITREV (seamless back-to-back frame);
    - else -> DRAIN.
  - DRAIN: 2 enabled edges, then IDLE. START=1 in DRAIN -> ISSUE, cnt=0, relatch BITREV; the pending pipeline still completes.
  - START in ISSUE with cnt!=63 is ignored.
- Latency: address k is presented after edge Ek. The RAM latches it at Ek+1, RAM_DO holds mem[addr k] after Ek+2, and DOUT/RDY are updated at Ek+3. The first sample of a frame appears 3 enabled edges after the START edge.
- Valid pipe: a 3-stage shift register fed by (state==ISSUE), plus a parallel first-flag pipe fed by (state==ISSUE && cnt==0).
  - RDY = stage 3. FIRST = first-flag stage 3.
  - DOUT <= RAM_DO when stage 2 is set; otherwise DOUT holds its previous value.
- RDY is high for exactly 64 enabled cycles per frame, contiguous when ED stays high. Back-to-back frames produce 128 contiguous RDY cycles, with FIRST at samples 0 and 64.
- BUSY falls on the edge where DRAIN exits, which is the same edge the last sample asserts RDY.
- Reset mid-frame aborts immediately: RDY, FIRST and BUSY drop asynchronously and no further samples are emitted.

Test Plan:
- Natural order: preload mem[i]=0x100+i, pulse START with BITREV=0, ED=1 -> RDY rises 3 edges after START; DOUT=0x100,0x101,...,0x13F over 64 cycles; FIRST only with 0x100; BUSY low after the last sample.
- Bit-reversed order: same preload, BITREV=1 -> DOUT sequence 0x100,0x120,0x110,0x130,0x108,... ending 0x13F; RAM_ADDR sequence 0,32,16,48,8,...,63.
- ED stall: hold ED=0 for 5 cycles starting at sample 10 -> DOUT, RDY and RAM_ADDR hold; the sequence resumes at sample 11 with no loss or duplication; total RDY-high enabled cycles = 64.
- Back-to-back: assert START at cnt=63 with BITREV toggled to 1 -> 128 contiguous RDY cycles; FIRST at samples 0 and 64; the second frame is bit-reversed.
- Ignored START: pulse START at cnt=20 -> no restart; exactly 64 samples are emitted in order.
- Reset mid-frame: assert RST at sample 30 -> RDY, FIRST, BUSY and DOUT are 0 immediately. A START after release yields a clean frame beginning 0x100.
